// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC read sequencer and the display register bank.
//   - RTC_TBL_LEN      : number of RTC registers swept per scan
//   - ST_*             : sequencer state encoding
//   - rtc_tbl_addr()   : scan index -> RTC register address
package rtc_pkg;

    localparam int RTC_TBL_LEN = 11;
    localparam int RTC_IDX_W   = 4;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_REQ  = 3'd1;
    localparam logic [2:0] ST_LOAD    = 3'd2;
    localparam logic [2:0] ST_NEXT    = 3'd3;
    localparam logic [2:0] ST_WR_REQ  = 3'd4;
    localparam logic [2:0] ST_WR_DONE = 3'd5;

    function automatic logic [7:0] rtc_tbl_addr(input logic [RTC_IDX_W-1:0] idx);
        logic [7:0] a;
        case (idx)
            4'd0:    a = 8'h21;
            4'd1:    a = 8'h22;
            4'd2:    a = 8'h23;
            4'd3:    a = 8'h24;
            4'd4:    a = 8'h25;
            4'd5:    a = 8'h26;
            4'd6:    a = 8'h27;
            4'd7:    a = 8'h28;
            4'd8:    a = 8'h41;
            4'd9:    a = 8'h42;
            4'd10:   a = 8'h43;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Periodic timer with terminal-count pulse.
//   clk, rst_n : clock, async active-low reset
//   en_i       : run; while low the count is held at zero
//   tc_o       : high for one cycle every PERIOD enabled cycles
// The first tc_o arrives in the PERIOD-th enabled cycle after the count
// leaves zero, so re-enabling restarts the full period. PERIOD must be >= 2.
module seq_timer #(
    parameter int unsigned PERIOD = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Zero acts as "reload" so the reset value of zero costs one extra
    // cycle, which together with the terminal count at one yields a
    // period of exactly PERIOD cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (!en_i) begin
            cnt_d = '0;
        end else if (cnt_q == '0) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = en_i && (cnt_q == CW'(1));

endmodule

// File: rtl/rtc_read_sequencer.sv
// Sweeps the RTC register table into the display register bank, on demand
// or periodically, and interleaves user write transactions.
//   clk, rst_n                    : clock, async active-low reset
//   start                         : request an immediate scan
//   wr_req, wr_addr, wr_data      : user write, held until wr_done
//   bus_req/we/addr/wdata         : transaction request to the RTC bus
//   bus_ack, bus_rdata            : transaction complete, read value
//   address, AoD, data_vga        : display bank load port (AoD low = load)
//   busy, wr_done, scan_done, err : status; err is a sticky timeout flag
//
// state      | meaning
// IDLE       | waiting for write, start or refresh expiry
// RD_REQ     | reading table[index] from the RTC
// LOAD       | one-cycle load of the captured value into the bank
// NEXT       | advance index, service a write, or finish the scan
// WR_REQ     | writing wr_data to wr_addr
// WR_DONE    | write complete, resume scan or return to idle
module rtc_read_sequencer
    import rtc_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 1_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       bus_req,
    output logic       bus_we,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic       bus_ack,
    input  logic [7:0] bus_rdata,
    output logic [7:0] address,
    output logic       AoD,
    output logic [7:0] data_vga,
    output logic       busy,
    output logic       wr_done,
    output logic       scan_done,
    output logic       err
);

    logic [2:0]           state_q, state_d;
    logic [RTC_IDX_W-1:0] idx_q, idx_d;
    logic [7:0]           rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic                 scan_done_q, scan_done_d;
    logic                 start_pend_q, start_pend_d;
    logic                 refr_pend_q, refr_pend_d;
    logic                 scan_act_q, scan_act_d;
    logic                 refr_tc, to_tc, in_bus_st;

    assign in_bus_st = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);

    seq_timer #(.PERIOD(REFRESH_CYCLES)) u_refresh (
        .clk  (clk),
        .rst_n(rst_n),
        .en_i (1'b1),
        .tc_o (refr_tc)
    );

    // Held at zero outside the bus states, so every entry into RD_REQ or
    // WR_REQ starts a fresh timeout window.
    seq_timer #(.PERIOD(TIMEOUT_CYCLES)) u_timeout (
        .clk  (clk),
        .rst_n(rst_n),
        .en_i (in_bus_st),
        .tc_o (to_tc)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        scan_done_d  = 1'b0;
        start_pend_d = start_pend_q;
        refr_pend_d  = refr_pend_q;
        scan_act_d   = scan_act_q;

        if (start) begin
            err_d = 1'b0;
        end
        if (refr_tc) begin
            refr_pend_d = 1'b1;
        end
        // A start that lands on a write (including one that wins priority
        // in IDLE) is remembered; a start mid-scan is dropped.
        if (start && ((state_q == ST_WR_REQ) || (state_q == ST_WR_DONE) ||
                      ((state_q == ST_IDLE) && wr_req))) begin
            start_pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (wr_req) begin
                    state_d = ST_WR_REQ;
                end else if (start || start_pend_q || refr_tc || refr_pend_q) begin
                    state_d      = ST_RD_REQ;
                    idx_d        = '0;
                    start_pend_d = 1'b0;
                    refr_pend_d  = 1'b0;
                    scan_act_d   = 1'b1;
                end
            end
            ST_RD_REQ: begin
                if (bus_ack) begin
                    rdata_d = bus_rdata;
                    state_d = ST_LOAD;
                end else if (to_tc) begin
                    err_d   = 1'b1;
                    state_d = ST_NEXT;
                end
            end
            ST_LOAD: begin
                state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (wr_req) begin
                    state_d = ST_WR_REQ;
                end else if (idx_q < RTC_IDX_W'(RTC_TBL_LEN - 1)) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_RD_REQ;
                end else begin
                    state_d     = ST_IDLE;
                    scan_done_d = 1'b1;
                    scan_act_d  = 1'b0;
                end
            end
            ST_WR_REQ: begin
                if (bus_ack || to_tc) begin
                    if (!bus_ack) begin
                        err_d = 1'b1;
                    end
                    state_d = ST_WR_DONE;
                end
            end
            ST_WR_DONE: begin
                state_d = scan_act_q ? ST_NEXT : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            scan_done_q  <= 1'b0;
            start_pend_q <= 1'b0;
            refr_pend_q  <= 1'b0;
            scan_act_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            scan_done_q  <= scan_done_d;
            start_pend_q <= start_pend_d;
            refr_pend_q  <= refr_pend_d;
            scan_act_q   <= scan_act_d;
        end
    end

    // Outputs decode straight from the state so reset reaches them
    // asynchronously and the bank address is zero outside LOAD.
    assign busy      = (state_q != ST_IDLE);
    assign bus_req   = in_bus_st;
    assign bus_we    = (state_q == ST_WR_REQ);
    assign bus_addr  = (state_q == ST_RD_REQ) ? rtc_tbl_addr(idx_q) :
                       (state_q == ST_WR_REQ) ? wr_addr : 8'h00;
    assign bus_wdata = (state_q == ST_WR_REQ) ? wr_data : 8'h00;
    assign address   = (state_q == ST_LOAD) ? rtc_tbl_addr(idx_q) : 8'h00;
    assign AoD       = (state_q != ST_LOAD);
    assign data_vga  = rdata_q;
    assign wr_done   = (state_q == ST_WR_DONE);
    assign scan_done = scan_done_q;
    assign err       = err_q;

endmodule
